nx_node_loader: RTL

- Host-side message encoder that programs a single mesh node.
- Takes one programming request (target row/column, instruction count, output count, loopback mask) plus a stream of instruction words.
- Serialises them into the node_load, node_loopback and node_control messages that each node's decoder consumes.
- Sits between the host/control interface and a mesh ingress port; its outbound stream is a standard MESSAGE_WIDTH valid/ready stream.

---
 rtl/nx_node_loader_pkg.sv | 75 +++++++
 rtl/nx_msg_out_reg.sv | 35 +++
 rtl/nx_node_loader.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/nx_node_loader_pkg.sv
// Shared node message definitions (the NXConstants set). The node decoder
// imports the same package so encoder and decoder agree bit-for-bit.
//
// Message layout, MSB first:
//   [63:60] row  [59:56] column  [55:54] command  [53:0] payload
// Payloads (zero padded at the top):
//   load     : address[41:32], data[31:0]
//   loopback : select[23:16], mask[15:0]
//   control  : num_instr[31:16], num_output[15:0]
package nx_node_loader_pkg;

  localparam int ROW_WIDTH        = 4;
  localparam int COLUMN_WIDTH     = 4;
  localparam int MESSAGE_WIDTH    = 64;
  localparam int NODE_PARAM_WIDTH = 16;

  localparam int NODE_ADDR_WIDTH  = 10;
  localparam int NODE_DATA_WIDTH  = 32;
  localparam int LB_SEG_WIDTH     = 16;
  localparam int LB_SEL_WIDTH     = 8;

  typedef enum logic [1:0] {
    NODE_LOAD     = 2'd0,
    NODE_LOOPBACK = 2'd1,
    NODE_SIGNAL   = 2'd2,
    NODE_CONTROL  = 2'd3
  } node_command_t;

  typedef struct packed {
    logic [ROW_WIDTH-1:0]    row;
    logic [COLUMN_WIDTH-1:0] column;
    node_command_t           command;
  } node_header_t;

  localparam int HEADER_WIDTH  = $bits(node_header_t);
  localparam int PAYLOAD_WIDTH = MESSAGE_WIDTH - HEADER_WIDTH;

  typedef struct packed {
    logic [PAYLOAD_WIDTH-NODE_ADDR_WIDTH-NODE_DATA_WIDTH-1:0] pad;
    logic [NODE_ADDR_WIDTH-1:0]                               address;
    logic [NODE_DATA_WIDTH-1:0]                               data;
  } node_load_t;

  typedef struct packed {
    logic [PAYLOAD_WIDTH-LB_SEL_WIDTH-LB_SEG_WIDTH-1:0] pad;
    logic [LB_SEL_WIDTH-1:0]                           select;
    logic [LB_SEG_WIDTH-1:0]                           mask;
  } node_loopback_t;

  typedef struct packed {
    logic [PAYLOAD_WIDTH-2*NODE_PARAM_WIDTH-1:0] pad;
    logic [NODE_PARAM_WIDTH-1:0]                 num_instr;
    logic [NODE_PARAM_WIDTH-1:0]                 num_output;
  } node_control_t;

  typedef struct packed {
    node_header_t               header;
    logic [PAYLOAD_WIDTH-1:0]   payload;
  } node_message_t;

  function automatic node_message_t pack_message(
    input logic [ROW_WIDTH-1:0]    row,
    input logic [COLUMN_WIDTH-1:0] column,
    input node_command_t           command,
    input logic [PAYLOAD_WIDTH-1:0] payload
  );
    node_message_t m;
    m.header.row     = row;
    m.header.column  = column;
    m.header.command = command;
    m.payload        = payload;
    return m;
  endfunction

endpackage

// File: rtl/nx_msg_out_reg.sv
// Single-entry valid/ready output register.
//   clk, rst    : clock, synchronous active-high reset
//   load_valid  : upstream has a message to store
//   load_data   : message to store
//   load_ready  : register can accept this cycle (empty or draining)
//   msg_data    : held message, stable while msg_valid && !msg_ready
//   msg_valid   : register holds a message
//   msg_ready   : downstream consumes the held message
// A drain and a load in the same cycle overwrite with no bubble.
module nx_msg_out_reg #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic [WIDTH-1:0] msg_data,
  output logic             msg_valid,
  input  logic             msg_ready
);

  assign load_ready = !msg_valid || msg_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      msg_valid <= 1'b0;
      msg_data  <= '0;
    end else if (load_ready) begin
      msg_valid <= load_valid;
      if (load_valid) msg_data <= load_data;
    end
  end

endmodule

// File: rtl/nx_node_loader.sv
// Host-side encoder that programs one mesh node: accepts a request plus a
// stream of instruction words and emits load, loopback and control messages,
// in that order, on a valid/ready message stream.
//   i_clk, i_rst          : clock, synchronous active-high reset
//   o_idle                : no request in progress and output register empty
//   i_req_*               : programming request (row, column, counts, mask)
//   i_instr_*/o_instr_ready : instruction word stream
//   o_msg_*/i_msg_ready   : encoded message stream
//   o_error               : one-cycle pulse when a request is rejected
// INPUTS must be a multiple of LB_SEG_W.
module nx_node_loader
  import nx_node_loader_pkg::*;
#(
  parameter int INPUTS     = 32,
  parameter int RAM_ADDR_W = 10,
  parameter int RAM_DATA_W = 32,
  parameter int LB_SEG_W   = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  output logic                        o_idle,
  input  logic [ROW_WIDTH-1:0]        i_req_row,
  input  logic [COLUMN_WIDTH-1:0]     i_req_column,
  input  logic [NODE_PARAM_WIDTH-1:0] i_req_num_instr,
  input  logic [NODE_PARAM_WIDTH-1:0] i_req_num_output,
  input  logic [INPUTS-1:0]           i_req_loopback,
  input  logic                        i_req_valid,
  output logic                        o_req_ready,
  input  logic [RAM_DATA_W-1:0]       i_instr_data,
  input  logic                        i_instr_valid,
  output logic                        o_instr_ready,
  output logic [MESSAGE_WIDTH-1:0]    o_msg_data,
  output logic                        o_msg_valid,
  input  logic                        i_msg_ready,
  output logic                        o_error
);

  localparam int LB_SEGS   = INPUTS / LB_SEG_W;
  localparam int SEG_CNT_W = (LB_SEGS > 1) ? $clog2(LB_SEGS) : 1;
  localparam logic [NODE_PARAM_WIDTH-1:0] MAX_INSTR = NODE_PARAM_WIDTH'(2 ** RAM_ADDR_W);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_LOOPBACK, S_CONTROL} state_t;

  state_t                      state, state_next;
  logic [ROW_WIDTH-1:0]        row_q;
  logic [COLUMN_WIDTH-1:0]     column_q;
  logic [NODE_PARAM_WIDTH-1:0] num_instr_q;
  logic [NODE_PARAM_WIDTH-1:0] num_output_q;
  logic [INPUTS-1:0]           lb_mask_q;
  logic [NODE_PARAM_WIDTH-1:0] addr_cnt;
  logic [SEG_CNT_W-1:0]        seg_cnt;
  logic                        error_q;

  logic                        req_accept, instr_accept, seg_load;
  logic                        oversize;
  logic                        load_valid, load_ready;
  logic [MESSAGE_WIDTH-1:0]    load_data;
  node_load_t                  ld;
  node_loopback_t              lb;
  node_control_t               ctl;

  assign oversize = i_req_num_instr > MAX_INSTR;
  assign o_idle   = (state == S_IDLE) && !o_msg_valid;
  assign o_error  = error_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      row_q        <= '0;
      column_q     <= '0;
      num_instr_q  <= '0;
      num_output_q <= '0;
      lb_mask_q    <= '0;
      addr_cnt     <= '0;
      seg_cnt      <= '0;
      error_q      <= 1'b0;
    end else begin
      state   <= state_next;
      error_q <= 1'b0;
      if (req_accept) begin
        row_q        <= i_req_row;
        column_q     <= i_req_column;
        num_instr_q  <= i_req_num_instr;
        num_output_q <= i_req_num_output;
        lb_mask_q    <= i_req_loopback;
        addr_cnt     <= '0;
        seg_cnt      <= '0;
        error_q      <= oversize;
      end
      if (instr_accept) addr_cnt <= addr_cnt + 1'b1;
      if (seg_load)     seg_cnt  <= seg_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next    = state;
    o_req_ready   = 1'b0;
    o_instr_ready = 1'b0;
    req_accept    = 1'b0;
    instr_accept  = 1'b0;
    seg_load      = 1'b0;
    load_valid    = 1'b0;
    load_data     = '0;

    ld            = '0;
    ld.address    = NODE_ADDR_WIDTH'(addr_cnt);
    ld.data       = NODE_DATA_WIDTH'(i_instr_data);
    lb            = '0;
    lb.select     = LB_SEL_WIDTH'(seg_cnt);
    lb.mask       = LB_SEG_WIDTH'(lb_mask_q >> (LB_SEG_W * int'(seg_cnt)));
    ctl           = '0;
    ctl.num_instr  = num_instr_q;
    ctl.num_output = num_output_q;

    case (state)
      S_IDLE: begin
        o_req_ready = !o_msg_valid && !i_rst;
        if (i_req_valid && o_req_ready) begin
          req_accept = 1'b1;
          if (oversize)                   state_next = S_IDLE;
          else if (i_req_num_instr == '0) state_next = S_LOOPBACK;
          else                            state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        o_instr_ready = load_ready && !i_rst;
        if (i_instr_valid && o_instr_ready) begin
          instr_accept = 1'b1;
          load_valid   = 1'b1;
          load_data    = pack_message(row_q, column_q, NODE_LOAD, ld);
          if (addr_cnt == num_instr_q - 1'b1) state_next = S_LOOPBACK;
        end
      end
      S_LOOPBACK: begin
        load_valid = 1'b1;
        load_data  = pack_message(row_q, column_q, NODE_LOOPBACK, lb);
        if (load_ready) begin
          seg_load = 1'b1;
          if (seg_cnt == SEG_CNT_W'(LB_SEGS - 1)) state_next = S_CONTROL;
        end
      end
      S_CONTROL: begin
        load_valid = 1'b1;
        load_data  = pack_message(row_q, column_q, NODE_CONTROL, ctl);
        if (load_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  nx_msg_out_reg #(.WIDTH(MESSAGE_WIDTH)) u_out_reg (
    .clk        (i_clk),
    .rst        (i_rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .msg_data   (o_msg_data),
    .msg_valid  (o_msg_valid),
    .msg_ready  (i_msg_ready)
  );

endmodule
